// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: owns the PC, issues one instruction-memory read at a time,
// holds the returned word for decode and loads the downstream next-PC on acceptance.
// Optional misaligned-fetch check enabled by defining IFU_MISALIGN_CHECK_EN.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [31:0] npc,
  output logic [31:0] fetch_count,
  output logic        exc_misalign
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StValid} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        misalign_q, misalign_d;
  logic        npc_bad;

  // Misaligned next-PC detection; constant 0 when the check is compiled out.
`ifdef IFU_MISALIGN_CHECK_EN
  assign npc_bad = (npc[1:0] != 2'b00);
`else
  assign npc_bad = 1'b0;
`endif

  // Next-state and datapath updates; only one fetch is ever outstanding.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    count_d    = count_q;
    misalign_d = 1'b0;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (imem_gnt) begin
          if (imem_rvalid) begin
            // Zero-wait memory: data returns in the grant cycle.
            instr_d = imem_rdata;
            state_d = StValid;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = StValid;
        end
      end
      StValid: begin
        if (instr_ready) begin
          pc_d       = npc_bad ? EXC_PC : npc;
          misalign_d = npc_bad;
          count_d    = count_q + 32'd1;
          state_d    = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and architectural registers, asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      count_q    <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req     = (state_q == StReq);
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign instr        = instr_q;
  assign instr_valid  = (state_q == StValid);
  assign fetch_count  = count_q;
  assign exc_misalign = misalign_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus randomized traffic,
// all compared against a transaction-level model of the fetch unit.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] npc = 32'd0;
  logic [31:0] fetch_count;
  logic        exc_misalign;

  int total = 0;
  int bad = 0;

  ifu_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .npc          (npc),
    .fetch_count  (fetch_count),
    .exc_misalign (exc_misalign)
  );

  always #5 clk = ~clk;

  // Reference model: what the unit holds, not how it sequences.
  bit          m_dead;         // first cycle after reset release: nothing happens
  bit          m_outstanding;  // granted, response not yet seen
  bit          m_have;         // a word is held for decode
  logic [31:0] m_pc, m_instr, m_count;
  bit          m_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_dead = 1; m_outstanding = 0; m_have = 0;
    m_pc = 32'h0000_3000; m_instr = 32'd0; m_count = 32'd0; m_mis = 0;
  endtask

  // Apply one clock edge's worth of spec rules to the model.
  task automatic model_edge(input bit g, input bit rv, input logic [31:0] rd,
                            input bit rdy, input logic [31:0] np);
    m_mis = 0;
    if (m_dead) begin
      m_dead = 0;
    end else if (m_have) begin
      if (rdy) begin
        m_count = m_count + 1;
        m_have  = 0;
`ifdef IFU_MISALIGN_CHECK_EN
        if (np[1:0] != 2'b00) begin
          m_pc  = 32'h0000_4180;
          m_mis = 1;
        end else m_pc = np;
`else
        m_pc = np;
`endif
      end
    end else if (m_outstanding) begin
      if (rv) begin m_instr = rd; m_have = 1; m_outstanding = 0; end
    end else if (g) begin
      if (rv) begin m_instr = rd; m_have = 1; end
      else m_outstanding = 1;
    end
  endtask

  task automatic check_all();
    check("imem_req", {31'd0, imem_req}, {31'd0, !m_dead && !m_outstanding && !m_have});
    check("imem_addr", imem_addr, m_pc);
    check("pc", pc, m_pc);
    check("instr", instr, m_instr);
    check("instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
    check("fetch_count", fetch_count, m_count);
    check("exc_misalign", {31'd0, exc_misalign}, {31'd0, m_mis});
  endtask

  // Called just after a negedge: drive inputs, advance model, check at next negedge.
  task automatic step(input bit g, input bit rv, input logic [31:0] rd,
                      input bit rdy, input logic [31:0] np);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; instr_ready = rdy; npc = np;
    if (rst_n) model_edge(g, rv, rd, rdy, np);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Zero-wait memory, decode always ready, sequential PCs.
    step(1, 1, 32'h1111_0000, 1, m_pc + 4);   // IDLE dead cycle
    check("first_addr", imem_addr, 32'h0000_3000);
    check("first_req", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < 6; i++) step(1, 1, 32'h1111_0001 + i, 1, m_pc + 4);
    check("three_accepts", fetch_count, 32'd3);
    check("third_pc", pc, 32'h0000_300c);

    // Delayed grant, then response three cycles after grant.
    do_reset();
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'hdead_beef, 0, 0);  // rvalid without gnt is ignored
    step(0, 0, 0, 0, 0);
    check("req_held", {31'd0, imem_req}, 32'd1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'h2408_0005, 0, 0);
    check("slow_instr", instr, 32'h2408_0005);
    check("slow_valid", {31'd0, instr_valid}, 32'd1);

    // Five-cycle decode stall with noise on the memory side.
    for (int i = 0; i < 5; i++) step(1, 1, $urandom, 0, $urandom);
    check("stall_instr", instr, 32'h2408_0005);
    step(0, 0, 0, 1, 32'h0000_3050);
    check("after_stall_addr", imem_addr, 32'h0000_3050);

    // Reset while waiting for a response; late response during IDLE ignored.
    step(1, 0, 0, 0, 0);
    do_reset();
    step(0, 1, 32'hbad0_0bad, 0, 0);
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_addr", imem_addr, 32'h0000_3000);

    // Counter wrap from all-ones.
    step(1, 1, 32'h0000_0013, 0, 0);
    force dut.count_q = 32'hffff_ffff;
    #1;
    release dut.count_q;
    m_count = 32'hffff_ffff;
    step(0, 0, 0, 1, 32'h0000_3004);
    check("wrap", fetch_count, 32'd0);

    // Misaligned next PC.
    step(1, 1, 32'h0000_0033, 0, 0);
    step(0, 0, 0, 1, 32'h0000_3006);
`ifdef IFU_MISALIGN_CHECK_EN
    check("mis_pc", pc, 32'h0000_4180);
    check("mis_pulse", {31'd0, exc_misalign}, 32'd1);
`else
    check("mis_pc", pc, 32'h0000_3006);
    check("mis_pulse", {31'd0, exc_misalign}, 32'd0);
`endif
    step(0, 0, 0, 0, 0);
    check("mis_clear", {31'd0, exc_misalign}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step($urandom_range(0, 1), $urandom_range(0, 2) != 0, $urandom,
           $urandom_range(0, 2) != 0,
           ($urandom_range(0, 3) == 0) ? $urandom : (m_pc + 32'd4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
